// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MIPS memory-access pipeline stage. Takes the EX/MEM register
//            outputs, runs a req/ready handshake with data memory, formats
//            store lanes/byte enables, extracts and extends load data, and
//            loads the MEM/WB pipeline register. Raises o_m_stall while an
//            access is outstanding so the upstream stages hold.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_reset (sync, active-high), i_clk_en (global step enable)
//   i_ex_m_*       : EX/MEM register contents (address/ALU result, store
//                    data, rd, mem_read/mem_write, mem_to_reg, reg_write,
//                    halt, bhw_type {unsigned, size[1:0]})
//   o_dmem_*       : registered data-memory request (req/we/addr/be/wdata)
//   i_dmem_ready/rdata : memory completion and read word
//   o_m_stall      : combinational hold for IF/ID/EX and EX/MEM
//   o_m_wb_*       : MEM/WB register contents
//   o_m_misaligned : sticky misaligned-access flag (cleared by reset only)
// ============================================================================
module mem_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [31:0] i_ex_m_alu_result,
  input  logic [31:0] i_ex_m_write_data,
  input  logic [4:0]  i_ex_m_rd,
  input  logic        i_ex_m_mem_read,
  input  logic        i_ex_m_mem_write,
  input  logic        i_ex_m_mem_to_reg,
  input  logic        i_ex_m_reg_write,
  input  logic        i_ex_m_halt,
  input  logic [2:0]  i_ex_m_bhw_type,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_m_stall,
  output logic [31:0] o_m_wb_read_data,
  output logic [31:0] o_m_wb_alu_result,
  output logic [4:0]  o_m_wb_rd,
  output logic        o_m_wb_mem_to_reg,
  output logic        o_m_wb_reg_write,
  output logic        o_m_wb_halt,
  output logic        o_m_misaligned
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Bus registers
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [3:0]  dmem_be_q;
  logic [31:0] dmem_wdata_q;

  // MEM/WB registers
  logic [31:0] wb_read_data_q;
  logic [31:0] wb_alu_result_q;
  logic [4:0]  wb_rd_q;
  logic        wb_mem_to_reg_q;
  logic        wb_reg_write_q;
  logic        wb_halt_q;
  logic        misaligned_q;

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  logic       w_access;
  logic       w_is_byte;
  logic       w_is_half;
  logic       w_misaligned;
  logic [1:0] w_lane;

  assign w_access  = i_ex_m_mem_read | i_ex_m_mem_write;
  assign w_is_byte = (i_ex_m_bhw_type[1:0] == 2'b00);
  assign w_is_half = (i_ex_m_bhw_type[1:0] == 2'b01);
  assign w_lane    = i_ex_m_alu_result[1:0];

  // Any size other than byte/half is handled as a word access.
  assign w_misaligned = w_access &
                        ((w_is_half & w_lane[0]) |
                         (~w_is_byte & ~w_is_half & (w_lane != 2'b00)));

  // --------------------------------------------------------------------------
  // Store formatting: replicate data across all lanes so memory only needs
  // the byte enables to pick the right bytes.
  // --------------------------------------------------------------------------
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (i_ex_m_mem_write) begin
      if (w_is_byte) begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_ex_m_write_data[7:0]}};
      end else if (w_is_half) begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_ex_m_write_data[15:0]}};
      end else begin
        w_be    = 4'b1111;
        w_wdata = i_ex_m_write_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction. EX/MEM is frozen by the stall for the whole access, so
  // the lane/size fields on the inputs are still valid at completion.
  // --------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  always_comb begin
    w_ld_byte = 8'h0;
    w_ld_half = 16'h0;
    w_ld_data = i_dmem_rdata;
    case (w_lane)
      2'd0:    w_ld_byte = i_dmem_rdata[7:0];
      2'd1:    w_ld_byte = i_dmem_rdata[15:8];
      2'd2:    w_ld_byte = i_dmem_rdata[23:16];
      default: w_ld_byte = i_dmem_rdata[31:24];
    endcase
    w_ld_half = w_lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    if (w_is_byte) begin
      w_ld_data = i_ex_m_bhw_type[2] ? {24'h0, w_ld_byte}
                                     : {{24{w_ld_byte[7]}}, w_ld_byte};
    end else if (w_is_half) begin
      w_ld_data = i_ex_m_bhw_type[2] ? {16'h0, w_ld_half}
                                     : {{16{w_ld_half[15]}}, w_ld_half};
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and stall
  // --------------------------------------------------------------------------
  logic w_start;

  always_comb begin
    state_d   = state_q;
    o_m_stall = 1'b0;
    w_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_clk_en & w_access & ~w_misaligned) begin
          o_m_stall = 1'b1;
          w_start   = 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_clk_en & i_dmem_ready) begin
          state_d = S_IDLE;
        end else begin
          o_m_stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, bus and MEM/WB registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= S_IDLE;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= 32'h0;
      dmem_be_q       <= 4'h0;
      dmem_wdata_q    <= 32'h0;
      wb_read_data_q  <= 32'h0;
      wb_alu_result_q <= 32'h0;
      wb_rd_q         <= 5'h0;
      wb_mem_to_reg_q <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_halt_q       <= 1'b0;
      misaligned_q    <= 1'b0;
    end else if (i_clk_en) begin
      state_q <= state_d;

      if (w_start) begin
        dmem_we_q    <= i_ex_m_mem_write;
        dmem_addr_q  <= {i_ex_m_alu_result[31:2], 2'b00};
        dmem_be_q    <= w_be;
        dmem_wdata_q <= w_wdata;
      end

      if (!o_m_stall) begin
        wb_alu_result_q <= i_ex_m_alu_result;
        wb_rd_q         <= i_ex_m_rd;
        wb_mem_to_reg_q <= i_ex_m_mem_to_reg;
        wb_halt_q       <= i_ex_m_halt;
        // A misaligned load never reaches memory, so it must not commit.
        wb_reg_write_q  <= i_ex_m_reg_write & ~(w_misaligned & i_ex_m_mem_read);
        wb_read_data_q  <= (i_ex_m_mem_read & ~w_misaligned) ? w_ld_data : 32'h0;
      end else begin
        // Downstream re-sees the held instruction; insert a bubble.
        wb_reg_write_q <= 1'b0;
      end

      if ((state_q == S_IDLE) && w_misaligned) begin
        misaligned_q <= 1'b1;
      end
    end
  end

  assign o_dmem_req        = (state_q == S_BUSY);
  assign o_dmem_we         = dmem_we_q;
  assign o_dmem_addr       = dmem_addr_q;
  assign o_dmem_be         = dmem_be_q;
  assign o_dmem_wdata      = dmem_wdata_q;
  assign o_m_wb_read_data  = wb_read_data_q;
  assign o_m_wb_alu_result = wb_alu_result_q;
  assign o_m_wb_rd         = wb_rd_q;
  assign o_m_wb_mem_to_reg = wb_mem_to_reg_q;
  assign o_m_wb_reg_write  = wb_reg_write_q;
  assign o_m_wb_halt       = wb_halt_q;
  assign o_m_misaligned    = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: directed cases for stores,
//            signed/unsigned loads, wait states with clock-enable gaps,
//            misaligned accesses and reset during an access, then a
//            randomized instruction stream against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [31:0] ex_alu;
  logic [31:0] ex_wd;
  logic [4:0]  ex_rd;
  logic        ex_mr, ex_mw, ex_m2r, ex_rw, ex_halt;
  logic [2:0]  ex_bhw;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        m_stall;
  logic [31:0] wb_read_data, wb_alu;
  logic [4:0]  wb_rd;
  logic        wb_m2r, wb_rw, wb_halt;
  logic        m_mis;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        exp_mis;
  logic [31:0] last_alu;

  mem_stage u_dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_clk_en          (clk_en),
    .i_ex_m_alu_result (ex_alu),
    .i_ex_m_write_data (ex_wd),
    .i_ex_m_rd         (ex_rd),
    .i_ex_m_mem_read   (ex_mr),
    .i_ex_m_mem_write  (ex_mw),
    .i_ex_m_mem_to_reg (ex_m2r),
    .i_ex_m_reg_write  (ex_rw),
    .i_ex_m_halt       (ex_halt),
    .i_ex_m_bhw_type   (ex_bhw),
    .o_dmem_req        (dmem_req),
    .o_dmem_we         (dmem_we),
    .o_dmem_addr       (dmem_addr),
    .o_dmem_be         (dmem_be),
    .o_dmem_wdata      (dmem_wdata),
    .i_dmem_ready      (dmem_ready),
    .i_dmem_rdata      (dmem_rdata),
    .o_m_stall         (m_stall),
    .o_m_wb_read_data  (wb_read_data),
    .o_m_wb_alu_result (wb_alu),
    .o_m_wb_rd         (wb_rd),
    .o_m_wb_mem_to_reg (wb_m2r),
    .o_m_wb_reg_write  (wb_rw),
    .o_m_wb_halt       (wb_halt),
    .o_m_misaligned    (m_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model, written from the access rules with plain arithmetic
  // --------------------------------------------------------------------------
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int          lane;
    lane = int'(a[1:0]);
    if (t[1:0] == 2'b00) begin
      v = (rd >> (8 * lane)) & 32'hFF;
      if (!t[2] && v >= 32'd128) v = v - 32'd256;
    end else if (t[1:0] == 2'b01) begin
      v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      if (!t[2] && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] t,
                                          input logic st);
    int lane;
    lane = int'(a[1:0]);
    if (!st)                 return 4'hF;
    if (t[1:0] == 2'b00)     return 4'((1 << lane) & 15);
    if (t[1:0] == 2'b01)     return 4'((3 << (2 * (lane / 2))) & 15);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] t);
    if (t[1:0] == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (t[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic model_mis(input logic [31:0] a, input logic [2:0] t, input logic acc);
    if (!acc)            return 1'b0;
    if (t[1:0] == 2'b00) return 1'b0;
    if (t[1:0] == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  // --------------------------------------------------------------------------
  // Issue one instruction at a negedge and follow it to MEM/WB.
  // lat = BUSY cycles without ready; ce_drop = clk_en low on first ready cycle.
  // --------------------------------------------------------------------------
  task automatic do_instr(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic m2r, input logic rw,
                          input logic hlt, input logic [2:0] bhw, input int lat,
                          input logic ce_drop, input logic [31:0] rdata);
    logic        acc, mis, exp_rw;
    logic [31:0] exp_addr;
    acc      = mr | mw;
    mis      = model_mis(alu, bhw, acc);
    exp_rw   = rw & ~(mis & mr);
    exp_addr = alu & 32'hFFFF_FFFC;

    ex_alu = alu; ex_wd = wd; ex_rd = rd; ex_mr = mr; ex_mw = mw;
    ex_m2r = m2r; ex_rw = rw; ex_halt = hlt; ex_bhw = bhw;
    clk_en = 1'b1;
    dmem_ready = 1'($urandom % 2);   // ignored while idle
    dmem_rdata = $urandom;
    #1;
    if (!acc || mis) begin
      check("stall_pass", m_stall, 0);
      @(posedge clk); @(negedge clk);
      if (mis) exp_mis = 1'b1;
      check("req_pass",  dmem_req, 0);
      check("mis_flag",  m_mis, exp_mis);
      check("wb_alu",    wb_alu, alu);
      check("wb_rd",     wb_rd, rd);
      check("wb_m2r",    wb_m2r, m2r);
      check("wb_rw",     wb_rw, exp_rw);
      check("wb_halt",   wb_halt, hlt);
      check("wb_rdata0", wb_read_data, 0);
    end else begin
      check("stall_idle", m_stall, 1);
      @(posedge clk); @(negedge clk);
      dmem_ready = 1'b0;
      check("req_busy",   dmem_req, 1);
      check("we",         dmem_we, mw);
      check("addr",       dmem_addr, exp_addr);
      check("be",         dmem_be, model_be(alu, bhw, mw));
      if (mw) check("wdata", dmem_wdata, model_wdata(wd, bhw));
      check("bubble_rw",  wb_rw, 0);
      check("wb_hold",    wb_alu, last_alu);
      for (int k = 0; k < lat; k++) begin
        clk_en = 1'($urandom % 2);
        #1;
        check("stall_wait", m_stall, 1);
        @(posedge clk); @(negedge clk);
        check("req_wait",  dmem_req, 1);
        check("addr_hold", dmem_addr, exp_addr);
        check("wb_hold_w", wb_alu, last_alu);
      end
      dmem_ready = 1'b1;
      dmem_rdata = rdata;
      if (ce_drop) begin
        clk_en = 1'b0;
        #1;
        check("stall_ce0", m_stall, 1);
        @(posedge clk); @(negedge clk);
        check("req_ce0",   dmem_req, 1);
        check("rw_ce0",    wb_rw, 0);
        check("alu_ce0",   wb_alu, last_alu);
      end
      clk_en = 1'b1;
      #1;
      check("stall_done", m_stall, 0);
      @(posedge clk); @(negedge clk);
      dmem_ready = 1'b0;
      check("req_done",  dmem_req, 0);
      check("mis_keep",  m_mis, exp_mis);
      check("wb_alu_m",  wb_alu, alu);
      check("wb_rd_m",   wb_rd, rd);
      check("wb_m2r_m",  wb_m2r, m2r);
      check("wb_rw_m",   wb_rw, rw);
      check("wb_halt_m", wb_halt, hlt);
      check("wb_rdata",  wb_read_data, mr ? model_load(alu, bhw, rdata) : 32'h0);
    end
    last_alu = alu;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   dmem_req, 0);
    check({tag, "_we"},    dmem_we, 0);
    check({tag, "_addr"},  dmem_addr, 0);
    check({tag, "_be"},    dmem_be, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_wbd"},   wb_read_data, 0);
    check({tag, "_wba"},   wb_alu, 0);
    check({tag, "_wbrd"},  wb_rd, 0);
    check({tag, "_wbm"},   wb_m2r, 0);
    check({tag, "_wbrw"},  wb_rw, 0);
    check({tag, "_wbh"},   wb_halt, 0);
    check({tag, "_mis"},   m_mis, 0);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    ex_alu = '0; ex_wd = '0; ex_rd = '0; ex_mr = 0; ex_mw = 0;
    ex_m2r = 0; ex_rw = 0; ex_halt = 0; ex_bhw = '0;
    dmem_ready = 0; dmem_rdata = '0;
    exp_mis = 1'b0; last_alu = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst");

    // SB 0xAB at 0x6, ready on first BUSY cycle
    do_instr(32'h6, 32'hAB, 5'd0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0);
    // LB / LBU at 0x3, LH at 0x2
    do_instr(32'h3, 32'h0, 5'd4, 1, 0, 1, 1, 0, 3'b000, 0, 0, 32'h80FF_FF7F);
    check("lb_dir", wb_read_data, 32'hFFFF_FF80);
    do_instr(32'h3, 32'h0, 5'd5, 1, 0, 1, 1, 0, 3'b100, 0, 0, 32'h80FF_FF7F);
    check("lbu_dir", wb_read_data, 32'h0000_0080);
    do_instr(32'h2, 32'h0, 5'd6, 1, 0, 1, 1, 0, 3'b001, 0, 0, 32'h80FF_FF7F);
    check("lh_dir", wb_read_data, 32'hFFFF_80FF);
    // Wait states with clk_en low on the ready cycle
    do_instr(32'h100, 32'h0, 5'd7, 1, 0, 1, 1, 0, 3'b011, 3, 1, 32'h1234_5678);
    // Misaligned LW
    do_instr(32'h2, 32'h0, 5'd8, 1, 0, 1, 1, 0, 3'b011, 0, 0, 32'h0);
    check("mis_dir", m_mis, 1);
    do_instr(32'h44, 32'h0, 5'd9, 0, 0, 0, 1, 0, 3'b011, 0, 0, 32'h0);
    check("mis_sticky", m_mis, 1);

    // Reset during the second BUSY cycle
    ex_alu = 32'h10; ex_wd = 32'hDEAD_BEEF; ex_rd = 5'd0; ex_mr = 0; ex_mw = 1;
    ex_m2r = 0; ex_rw = 0; ex_halt = 0; ex_bhw = 3'b011;
    clk_en = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rb_req1", dmem_req, 1);
    @(posedge clk); @(negedge clk);
    check("rb_req2", dmem_req, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_mis = 1'b0; last_alu = '0;
    check_all_zero("rbusy");
    do_instr(32'h0000_1234, 32'h0, 5'd3, 0, 0, 0, 1, 0, 3'b011, 0, 0, 32'h0);

    // Randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a;
      logic [2:0]  t;
      int          kind, sz;
      logic        mr, mw;
      a    = $urandom;
      if ($urandom % 2) a = a & 32'hFFFF_FFFC;
      sz   = int'($urandom % 3);
      t    = (sz == 0) ? 3'b000 : (sz == 1) ? 3'b001 : 3'b011;
      if (sz != 2) t[2] = 1'($urandom % 2);
      kind = int'($urandom % 4);
      mr   = (kind == 1);
      mw   = (kind == 2);
      do_instr(a, $urandom, 5'($urandom), mr, mw, 1'($urandom % 2), 1'($urandom % 2),
               1'($urandom % 2), t, int'($urandom % 4), 1'($urandom % 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
